// File: rtl/mips_defs_pkg.sv
// mips_defs: definitions shared by the MEM-stage files.
//   Opcode constants for the loads and stores the MEM stage understands,
//   default data-memory geometry, the Tnew field width, the load-kind
//   encoding passed from decode to the memory core, and the Tnew
//   saturating-decrement helper.
package mips_defs;

   localparam int DM_WORDS_DEF = 3072;
   localparam int IDX_BITS_DEF = 12;
   localparam int TNEW_W       = 2;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   typedef enum logic [2:0] {
      LD_NONE,
      LD_W,
      LD_H,
      LD_HU,
      LD_B,
      LD_BU
   } load_kind_e;

   // Tnew counts down one per stage and never wraps below zero.
   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/mem_wb_stage_dm_core.sv
// dm_core: on-chip data memory for the MEM stage.
//   clk, reset   : clock, synchronous active-high reset (clears every word)
//   byte_en[3:0] : lanes to write this cycle (all zero = no store)
//   addr[31:0]   : byte address of the access
//   wdata[31:0]  : store data, already replicated into the selected lanes
//   pc[31:0]     : PC of the accessing instruction, used in the store log
//   load_kind    : which load (if any) is in MEM
//   load_data    : combinational, lane-selected and extended load result
module dm_core
   import mips_defs::*;
#(
   parameter int DM_WORDS = DM_WORDS_DEF,
   parameter int IDX_BITS = IDX_BITS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       byte_en,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic [31:0]      pc,
   input  load_kind_e       load_kind,
   output logic [31:0]      load_data
);

   localparam logic [IDX_BITS:0] WORD_LIMIT = DM_WORDS[IDX_BITS:0];

   logic [31:0]         mem [DM_WORDS];
   logic [IDX_BITS-1:0] idx;
   logic                in_range;
   logic [31:0]         cur_word;
   logic [31:0]         new_word;
   logic [7:0]          sel_byte;
   logic [15:0]         sel_half;

   assign idx = addr[IDX_BITS+1:2];

   // Bits above the index must be zero too, so high addresses never alias
   // back into the array.
   assign in_range = (addr[31:IDX_BITS+2] == '0) && ({1'b0, idx} < WORD_LIMIT);

   always_comb begin
      cur_word = '0;
      if (in_range)
         cur_word = mem[idx];
      new_word = cur_word;
      for (int b = 0; b < 4; b++)
         if (byte_en[b])
            new_word[8*b +: 8] = wdata[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++)
            mem[i] <= '0;
      end else if ((byte_en != 4'b0000) && in_range) begin
         mem[idx] <= new_word;
         $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, new_word);
      end
   end

   assign sel_byte = cur_word[8*addr[1:0] +: 8];
   assign sel_half = addr[1] ? cur_word[31:16] : cur_word[15:0];

   always_comb begin
      load_data = '0;
      case (load_kind)
         LD_W:    load_data = cur_word;
         LD_H:    load_data = {{16{sel_half[15]}}, sel_half};
         LD_HU:   load_data = {16'h0000, sel_half};
         LD_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         LD_BU:   load_data = {24'h000000, sel_byte};
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the five-stage MIPS pipeline plus the MEM/WB
// register. Decodes the EX/MEM instruction, drives stores and loads into
// dm_core, and registers everything WB needs.
//   clk, reset                    : clock, synchronous active-high reset
//   InstrIn, EResultIn, RData2In  : instruction, address/ALU result, store data
//   RegWriteIn, curPCIn, TnewIn   : control carried from EX/MEM
//   InstrOut, EResultOut, curPCOut, RegWriteOut : MEM/WB copies
//   MemDataOut                    : extended load data (0 for non-loads)
//   TnewOut                       : Tnew decremented with saturation at 0
module mem_wb_stage
   import mips_defs::*;
#(
   parameter int DM_WORDS = DM_WORDS_DEF,
   parameter int IDX_BITS = IDX_BITS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       InstrIn,
   input  logic [31:0]       EResultIn,
   input  logic [31:0]       RData2In,
   input  logic              RegWriteIn,
   input  logic [31:0]       curPCIn,
   input  logic [TNEW_W-1:0] TnewIn,
   output logic [31:0]       InstrOut,
   output logic [31:0]       EResultOut,
   output logic [31:0]       curPCOut,
   output logic [31:0]       MemDataOut,
   output logic              RegWriteOut,
   output logic [TNEW_W-1:0] TnewOut
);

   logic [5:0]  opcode;
   load_kind_e  load_kind;
   logic [3:0]  byte_en;
   logic [31:0] wdata;
   logic [31:0] load_data;

   assign opcode = InstrIn[31:26];

   // Lane data is replicated so the byte enables alone pick the lane.
   always_comb begin
      load_kind = LD_NONE;
      byte_en   = 4'b0000;
      wdata     = RData2In;
      case (opcode)
         OP_LW:  load_kind = LD_W;
         OP_LH:  load_kind = LD_H;
         OP_LHU: load_kind = LD_HU;
         OP_LB:  load_kind = LD_B;
         OP_LBU: load_kind = LD_BU;
         OP_SW:  byte_en   = 4'b1111;
         OP_SH: begin
            byte_en = EResultIn[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{RData2In[15:0]}};
         end
         OP_SB: begin
            byte_en = 4'b0001 << EResultIn[1:0];
            wdata   = {4{RData2In[7:0]}};
         end
         default: ;
      endcase
   end

   dm_core #(
      .DM_WORDS (DM_WORDS),
      .IDX_BITS (IDX_BITS)
   ) u_dm (
      .clk       (clk),
      .reset     (reset),
      .byte_en   (byte_en),
      .addr      (EResultIn),
      .wdata     (wdata),
      .pc        (curPCIn),
      .load_kind (load_kind),
      .load_data (load_data)
   );

   // MEM/WB register
   always_ff @(posedge clk) begin
      if (reset) begin
         InstrOut    <= '0;
         EResultOut  <= '0;
         curPCOut    <= '0;
         MemDataOut  <= '0;
         RegWriteOut <= 1'b0;
         TnewOut     <= '0;
      end else begin
         InstrOut    <= InstrIn;
         EResultOut  <= EResultIn;
         curPCOut    <= curPCIn;
         MemDataOut  <= (load_kind != LD_NONE) ? load_data : 32'h0;
         RegWriteOut <= RegWriteIn;
         TnewOut     <= tnew_dec(TnewIn);
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed bench for mem_wb_stage with a scoreboard of
// expected MEM/WB register contents.
module tb_mem_wb_stage;
   import mips_defs::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] InstrIn = '0;
   logic [31:0] EResultIn = '0;
   logic [31:0] RData2In = '0;
   logic        RegWriteIn = 1'b0;
   logic [31:0] curPCIn = '0;
   logic [1:0]  TnewIn = '0;
   logic [31:0] InstrOut, EResultOut, curPCOut, MemDataOut;
   logic        RegWriteOut;
   logic [1:0]  TnewOut;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] eres;
      logic [31:0] pc;
      logic [31:0] mdata;
      logic        rw;
      logic [1:0]  tnew;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   logic [31:0] pc_ctr = 32'h0000_3000;

   mem_wb_stage dut (
      .clk         (clk),
      .reset       (reset),
      .InstrIn     (InstrIn),
      .EResultIn   (EResultIn),
      .RData2In    (RData2In),
      .RegWriteIn  (RegWriteIn),
      .curPCIn     (curPCIn),
      .TnewIn      (TnewIn),
      .InstrOut    (InstrOut),
      .EResultOut  (EResultOut),
      .curPCOut    (curPCOut),
      .MemDataOut  (MemDataOut),
      .RegWriteOut (RegWriteOut),
      .TnewOut     (TnewOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one instruction into MEM for one cycle, push its expected MEM/WB
   // contents, then pop and compare after the edge.
   task automatic step(input string tag, input logic rst, input logic [5:0] op,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic rw, input logic [1:0] tnew,
                       input logic [31:0] exp_mdata);
      exp_t e;
      exp_t got;
      reset      = rst;
      InstrIn    = {op, 26'h0A5_1234 ^ {20'h0, addr[5:0]}};
      EResultIn  = addr;
      RData2In   = data;
      RegWriteIn = rw;
      curPCIn    = pc_ctr;
      TnewIn     = tnew;
      if (rst) begin
         e = '{instr: 32'h0, eres: 32'h0, pc: 32'h0, mdata: 32'h0, rw: 1'b0, tnew: 2'd0};
      end else begin
         e.instr = InstrIn;
         e.eres  = addr;
         e.pc    = pc_ctr;
         e.mdata = exp_mdata;
         e.rw    = rw;
         e.tnew  = (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
      end
      sb_q.push_back(e);
      pc_ctr = pc_ctr + 32'd4;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: scoreboard empty, observed %h expected entry", tag, MemDataOut);
      end else begin
         got = sb_q.pop_front();
         check({tag, ".mdata"}, MemDataOut, got.mdata);
         check({tag, ".instr"}, InstrOut, got.instr);
         check({tag, ".eres"},  EResultOut, got.eres);
         check({tag, ".pc"},    curPCOut, got.pc);
         check({tag, ".rw"},    {31'h0, RegWriteOut}, {31'h0, got.rw});
         check({tag, ".tnew"},  {30'h0, TnewOut}, {30'h0, got.tnew});
      end
   endtask

   initial begin
      // Reset with a store presented: nothing written, outputs cleared.
      step("rst",       1'b1, OP_SW,    32'h10,    32'hDEADBEEF, 1'b1, 2'd2, 32'h0);
      step("lw0",       1'b0, OP_LW,    32'h0,     32'h0,        1'b1, 2'd0, 32'h0);
      step("lw10_pre",  1'b0, OP_LW,    32'h10,    32'h0,        1'b1, 2'd0, 32'h0);

      // Word store / load.
      step("sw10",      1'b0, OP_SW,    32'h10,    32'h12345678, 1'b0, 2'd0, 32'h0);
      step("lw10",      1'b0, OP_LW,    32'h10,    32'h0,        1'b1, 2'd1, 32'h12345678);

      // Byte store and byte loads.
      step("lw20",      1'b0, OP_LW,    32'h20,    32'h0,        1'b1, 2'd1, 32'h0);
      step("sb22",      1'b0, OP_SB,    32'h22,    32'h000000F0, 1'b0, 2'd0, 32'h0);
      step("lw20b",     1'b0, OP_LW,    32'h20,    32'h0,        1'b1, 2'd1, 32'h00F00000);
      step("lb22",      1'b0, OP_LB,    32'h22,    32'h0,        1'b1, 2'd1, 32'hFFFFFFF0);
      step("lbu22",     1'b0, OP_LBU,   32'h22,    32'h0,        1'b1, 2'd1, 32'h000000F0);

      // Half store and half loads.
      step("sh32",      1'b0, OP_SH,    32'h32,    32'h00008001, 1'b0, 2'd0, 32'h0);
      step("lw30",      1'b0, OP_LW,    32'h30,    32'h0,        1'b1, 2'd1, 32'h80010000);
      step("lh32",      1'b0, OP_LH,    32'h32,    32'h0,        1'b1, 2'd1, 32'hFFFF8001);
      step("lhu30",     1'b0, OP_LHU,   32'h30,    32'h0,        1'b1, 2'd1, 32'h00000000);
      step("sh35",      1'b0, OP_SH,    32'h35,    32'hFFFF1234, 1'b0, 2'd0, 32'h0);
      step("lw34",      1'b0, OP_LW,    32'h34,    32'h0,        1'b1, 2'd1, 32'h00001234);

      // Word store ignores addr[1:0]; mixed lane reads; byte overwrite.
      step("sw43",      1'b0, OP_SW,    32'h43,    32'hCAFEBABE, 1'b0, 2'd0, 32'h0);
      step("lw40",      1'b0, OP_LW,    32'h40,    32'h0,        1'b1, 2'd1, 32'hCAFEBABE);
      step("lb41",      1'b0, OP_LB,    32'h41,    32'h0,        1'b1, 2'd1, 32'hFFFFFFBA);
      step("lbu43",     1'b0, OP_LBU,   32'h43,    32'h0,        1'b1, 2'd1, 32'h000000CA);
      step("lh40",      1'b0, OP_LH,    32'h40,    32'h0,        1'b1, 2'd1, 32'hFFFFBABE);
      step("lhu42",     1'b0, OP_LHU,   32'h42,    32'h0,        1'b1, 2'd1, 32'h0000CAFE);
      step("sb41",      1'b0, OP_SB,    32'h41,    32'hABCDEF11, 1'b0, 2'd0, 32'h0);
      step("lw40b",     1'b0, OP_LW,    32'h40,    32'h0,        1'b1, 2'd1, 32'hCAFE11BE);

      // Tnew saturation and control passthrough; a non-load reports 0.
      step("tnew3",     1'b0, 6'b001001, 32'h10,   32'h0,        1'b1, 2'd3, 32'h0);
      step("tnew2",     1'b0, 6'b001001, 32'h40,   32'h0,        1'b1, 2'd2, 32'h0);
      step("tnew0",     1'b0, 6'b000000, 32'h0,    32'h0,        1'b0, 2'd0, 32'h0);

      // Range edges: last word is usable, beyond it is dropped / reads 0.
      step("sw2ffc",    1'b0, OP_SW,    32'h2FFC,  32'h55AA55AA, 1'b0, 2'd0, 32'h0);
      step("lw2ffc",    1'b0, OP_LW,    32'h2FFC,  32'h0,        1'b1, 2'd1, 32'h55AA55AA);
      step("sw3000",    1'b0, OP_SW,    32'h3000,  32'hDEADBEEF, 1'b0, 2'd0, 32'h0);
      step("lw3000",    1'b0, OP_LW,    32'h3000,  32'h0,        1'b1, 2'd1, 32'h0);
      step("sw10010",   1'b0, OP_SW,    32'h10010, 32'hDEADBEEF, 1'b0, 2'd0, 32'h0);
      step("lw10_keep", 1'b0, OP_LW,    32'h10,    32'h0,        1'b1, 2'd1, 32'h12345678);
      step("lw0_keep",  1'b0, OP_LW,    32'h0,     32'h0,        1'b1, 2'd1, 32'h0);

      // Mid-program reset with a store presented, then normal capture.
      step("rst2",      1'b1, OP_SW,    32'h10,    32'h00000077, 1'b1, 2'd1, 32'h0);
      step("lw10_rst",  1'b0, OP_LW,    32'h10,    32'h0,        1'b1, 2'd2, 32'h0);
      step("lw40_rst",  1'b0, OP_LW,    32'h40,    32'h0,        1'b1, 2'd1, 32'h0);

      tests++;
      assert (sb_q.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain: observed %0d expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
